// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - access size encodings (mem_size_in / dm_size_out)
//     - FSM state enum for the read-modify-write sequencer
//     - lane_sel(): physical byte lane holding the low byte of a sub-word
//       access, for either byte ordering
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_ILLEGAL = 2'b10;
  localparam logic [1:0] SZ_WORD    = 2'b11;

  typedef enum logic {
    LSU_IDLE      = 1'b0,
    LSU_RMW_WRITE = 1'b1
  } lsu_state_e;

  // Returns the physical lane (0 = bits [7:0]) of the least significant
  // byte of the addressed item. Big-endian byte k lives in lane 3-k, and a
  // big-endian halfword at offset 0 occupies the upper lanes (2 and 3).
  function automatic logic [1:0] lane_sel(input logic [1:0] addr_lo,
                                          input logic [1:0] size,
                                          input logic       big_endian);
    logic [1:0] lane;
    lane = 2'b00;
    case (size)
      SZ_BYTE: lane = big_endian ? ~addr_lo : addr_lo;
      SZ_HALF: lane = big_endian ? {~addr_lo[1], 1'b0} : {addr_lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//   Combinational byte-lane datapath shared by the load and RMW paths.
//   Ports:
//     word_in     - full memory word (data_memory read data)
//     store_data  - right-justified store data
//     size        - access size (SZ_BYTE / SZ_HALF / word otherwise)
//     lane        - physical lane of the item's least significant byte
//     signed_ext  - sign-extend sub-word load results
//     load_data   - extracted and extended load result
//     merged_word - word_in with the store item inserted at its lane
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        signed_ext,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt;
  logic [15:0] lane_bits;
  logic [31:0] lane_mask;

  assign shamt     = {lane, 3'b000};
  // Only the low 16 bits of the shifted word can ever be needed.
  assign lane_bits = 16'(word_in >> shamt);
  assign lane_mask = (size == SZ_BYTE) ? 32'h0000_00ff : 32'h0000_ffff;

  always_comb begin
    load_data   = word_in;
    merged_word = store_data;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{signed_ext & lane_bits[7]}}, lane_bits[7:0]};
        merged_word = (word_in & ~(lane_mask << shamt))
                    | ((store_data & lane_mask) << shamt);
      end
      SZ_HALF: begin
        load_data   = {{16{signed_ext & lane_bits[15]}}, lane_bits};
        merged_word = (word_in & ~(lane_mask << shamt))
                    | ((store_data & lane_mask) << shamt);
      end
      default: begin
        load_data   = word_in;
        merged_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Bridges the pipeline MEM stage to a word-only data_memory. Loads of any
//   size complete in the same cycle; sub-word stores perform a two-cycle
//   read-modify-write (stall on the read cycle), except in the MMIO region
//   where the item is written zero-extended in a single cycle.
//
//   Build option: define LSU_MISALIGN_TRAP_EN to report misaligned or
//   illegal-size accesses on misaligned_out (no memory traffic). Without it
//   addresses are force-aligned and size 2'b10 behaves as a word.
//
//   Ports:
//     clock, reset      - clock, synchronous active-high reset
//     mem_*_in          - pipeline request (write wins over read)
//     mem_rdata_out     - extended load result
//     stall_out         - pipeline must hold its mem_* inputs
//     misaligned_out    - access faulted
//     dm_*_out          - word access to data_memory (size always word)
//     dm_rdata_in       - combinational read data from data_memory
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [15:0] MMIO_PREFIX = 16'hffff,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_signed_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  output logic [31:0] mem_rdata_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic        dm_re_out,
  output logic        dm_we_out,
  output logic [1:0]  dm_size_out,
  input  logic [31:0] dm_rdata_in
);

  lsu_state_e  state_reg, state_next;
  logic [31:0] merge_q, merge_next;

  logic        misaligned;
  logic [1:0]  eff_size;
  logic [31:0] eff_addr;
  logic        is_mmio;
  logic        is_subword;
  logic [1:0]  lane;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [31:0] mmio_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((mem_size_in == SZ_HALF) && mem_addr_in[0])
                    || ((mem_size_in == SZ_WORD) && (mem_addr_in[1:0] != 2'b00))
                    || (mem_size_in == SZ_ILLEGAL);
  assign eff_size   = mem_size_in;
  assign eff_addr   = mem_addr_in;
`else
  assign misaligned = 1'b0;
  assign eff_size   = (mem_size_in == SZ_ILLEGAL) ? SZ_WORD : mem_size_in;
  always_comb begin
    eff_addr = mem_addr_in;
    case (eff_size)
      SZ_HALF: eff_addr = {mem_addr_in[31:1], 1'b0};
      SZ_WORD: eff_addr = {mem_addr_in[31:2], 2'b00};
      default: eff_addr = mem_addr_in;
    endcase
  end
`endif

  assign is_mmio    = (mem_addr_in[31:16] == MMIO_PREFIX);
  assign is_subword = (eff_size == SZ_BYTE) || (eff_size == SZ_HALF);
  assign lane       = lane_sel(eff_addr[1:0], eff_size, BIG_ENDIAN);
  // MMIO devices see sub-word data in the low bits regardless of lane.
  assign mmio_wdata = (eff_size == SZ_BYTE) ? {24'h0, mem_wdata_in[7:0]}
                                            : {16'h0, mem_wdata_in[15:0]};

  lsu_lane_align u_lane_align (
    .word_in     (dm_rdata_in),
    .store_data  (mem_wdata_in),
    .size        (eff_size),
    .lane        (lane),
    .signed_ext  (mem_signed_in),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LSU_IDLE;
      merge_q   <= 32'h0;
    end else begin
      state_reg <= state_next;
      merge_q   <= merge_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    merge_next     = merge_q;
    mem_rdata_out  = 32'h0;
    stall_out      = 1'b0;
    misaligned_out = 1'b0;
    dm_addr_out    = 32'h0;
    dm_wdata_out   = 32'h0;
    dm_re_out      = 1'b0;
    dm_we_out      = 1'b0;
    dm_size_out    = SZ_WORD;

    // Every output except the size stays quiet during reset, which also
    // suppresses a pending RMW write.
    if (!reset) begin
      dm_addr_out = {eff_addr[31:2], 2'b00};
      case (state_reg)
        LSU_IDLE: begin
          if (mem_write_in || mem_read_in) begin
            if (misaligned) begin
              misaligned_out = 1'b1;
            end else if (mem_write_in) begin
              if (!is_subword) begin
                dm_we_out    = 1'b1;
                dm_wdata_out = mem_wdata_in;
              end else if (is_mmio) begin
                dm_we_out    = 1'b1;
                dm_wdata_out = mmio_wdata;
              end else begin
                // Read phase: merge against the live read data and keep
                // the pipeline held for the write phase.
                dm_re_out  = 1'b1;
                stall_out  = 1'b1;
                merge_next = merged_word;
                state_next = LSU_RMW_WRITE;
              end
            end else begin
              dm_re_out     = 1'b1;
              mem_rdata_out = load_data;
            end
          end
        end
        LSU_RMW_WRITE: begin
          dm_we_out    = 1'b1;
          dm_wdata_out = merge_q;
          state_next   = LSU_IDLE;
        end
        default: state_next = LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed and randomized bench for load_store_unit (big-endian default).
//   The reference model keeps memory as individual bytes and derives every
//   expected load value / written word from byte addresses.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, mem_signed_in;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_addr_in, mem_wdata_in;
  logic [31:0] mem_rdata_out, dm_addr_out, dm_wdata_out, dm_rdata_in;
  logic        stall_out, misaligned_out, dm_re_out, dm_we_out;
  logic [1:0]  dm_size_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] last_rdata, last_wdata, last_addr;

  // data_memory stand-in: combinational read, write on rising edge
  logic [31:0] dmem [0:255];
  logic        tb_we = 1'b0;
  logic [31:0] tb_waddr = 32'h0, tb_wdata = 32'h0;

  // reference model: byte-addressed memory
  logic [7:0]  rbyte [0:1023];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [1:0] region(input logic [31:0] a);
    case (a[31:16])
      16'h1000: return 2'd0;
      16'h7fff: return 2'd1;
      16'hffff: return 2'd2;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] widx(input logic [31:0] a);
    return {region(a), a[7:2]};
  endfunction

  function automatic logic [9:0] ri(input logic [31:0] a);
    return {region(a), a[7:0]};
  endfunction

  assign dm_rdata_in = dmem[widx(dm_addr_out)];

  always @(posedge clock) begin
    if (dm_we_out)  dmem[widx(dm_addr_out)] <= dm_wdata_out;
    else if (tb_we) dmem[widx(tb_waddr)]    <= tb_wdata;
  end

  load_store_unit dut (
    .clock          (clock),
    .reset          (reset),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_size_in    (mem_size_in),
    .mem_signed_in  (mem_signed_in),
    .mem_addr_in    (mem_addr_in),
    .mem_wdata_in   (mem_wdata_in),
    .mem_rdata_out  (mem_rdata_out),
    .stall_out      (stall_out),
    .misaligned_out (misaligned_out),
    .dm_addr_out    (dm_addr_out),
    .dm_wdata_out   (dm_wdata_out),
    .dm_re_out      (dm_re_out),
    .dm_we_out      (dm_we_out),
    .dm_size_out    (dm_size_out),
    .dm_rdata_in    (dm_rdata_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {rbyte[ri(b)], rbyte[ri(b + 32'd1)], rbyte[ri(b + 32'd2)], rbyte[ri(b + 32'd3)]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'b00: begin
        b = rbyte[ri(a)];
        return sg ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'b01: begin
        h = {rbyte[ri(a)], rbyte[ri(a + 32'd1)]};
        return sg ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_put_word(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    rbyte[ri(b)]         = w[31:24];
    rbyte[ri(b + 32'd1)] = w[23:16];
    rbyte[ri(b + 32'd2)] = w[15:8];
    rbyte[ri(b + 32'd3)] = w[7:0];
  endtask

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00: rbyte[ri(a)] = d[7:0];
      2'b01: begin
        rbyte[ri(a)]         = d[15:8];
        rbyte[ri(a + 32'd1)] = d[7:0];
      end
      default: ref_put_word(a, d);
    endcase
  endtask

  // Preload one word into both memories through the bench write port.
  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    @(negedge clock);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
    ref_put_word(a, v);
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  task automatic idle_inputs();
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_signed_in = 1'b0;
    mem_size_in = 2'b11; mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
  endtask

  // One pipeline request; ends 1 ns after its final rising edge.
  task automatic op(input bit wr, input bit rd, input logic [1:0] sz, input bit sg,
                    input logic [31:0] a, input logic [31:0] d);
    bit          mis, mmio;
    logic [1:0]  esz;
    logic [31:0] ea, exp_w;
    mis  = TRAP && ((sz == 2'b01 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00) || sz == 2'b10);
    esz  = (!TRAP && sz == 2'b10) ? 2'b11 : sz;
    ea   = (esz == 2'b01) ? {a[31:1], 1'b0} : (esz == 2'b11) ? {a[31:2], 2'b00} : a;
    mmio = (a[31:16] == 16'hffff);
    @(negedge clock);
    mem_write_in = wr; mem_read_in = rd; mem_size_in = sz; mem_signed_in = sg;
    mem_addr_in = a; mem_wdata_in = d;
    #1;
    check("misaligned", {31'h0, misaligned_out}, {31'h0, mis});
    check("dm_size", {30'h0, dm_size_out}, 32'h3);
    if (mis) begin
      check("mis_re", {31'h0, dm_re_out}, 32'h0);
      check("mis_we", {31'h0, dm_we_out}, 32'h0);
      check("mis_rdata", mem_rdata_out, 32'h0);
      check("mis_stall", {31'h0, stall_out}, 32'h0);
    end else if (wr) begin
      if (esz == 2'b11 || mmio) begin
        exp_w = (esz == 2'b11) ? d : (esz == 2'b00) ? {24'h0, d[7:0]} : {16'h0, d[15:0]};
        check("st_we", {31'h0, dm_we_out}, 32'h1);
        check("st_re", {31'h0, dm_re_out}, 32'h0);
        check("st_stall", {31'h0, stall_out}, 32'h0);
        check("st_addr", dm_addr_out, {ea[31:2], 2'b00});
        check("st_wdata", dm_wdata_out, exp_w);
        ref_put_word(ea, exp_w);
      end else begin
        check("rmw_rd_re", {31'h0, dm_re_out}, 32'h1);
        check("rmw_rd_we", {31'h0, dm_we_out}, 32'h0);
        check("rmw_rd_stall", {31'h0, stall_out}, 32'h1);
        check("rmw_rd_addr", dm_addr_out, {ea[31:2], 2'b00});
        @(posedge clock);
        #1;
        ref_store(ea, esz, d);
        check("rmw_wr_we", {31'h0, dm_we_out}, 32'h1);
        check("rmw_wr_re", {31'h0, dm_re_out}, 32'h0);
        check("rmw_wr_stall", {31'h0, stall_out}, 32'h0);
        check("rmw_wr_addr", dm_addr_out, {ea[31:2], 2'b00});
        check("rmw_wr_wdata", dm_wdata_out, ref_word(ea));
      end
    end else begin
      check("ld_re", {31'h0, dm_re_out}, 32'h1);
      check("ld_we", {31'h0, dm_we_out}, 32'h0);
      check("ld_stall", {31'h0, stall_out}, 32'h0);
      check("ld_addr", dm_addr_out, {ea[31:2], 2'b00});
      check("ld_rdata", mem_rdata_out, ref_load(ea, esz, sg));
    end
    last_rdata = mem_rdata_out;
    last_wdata = dm_wdata_out;
    last_addr  = dm_addr_out;
    @(posedge clock);
    #1 idle_inputs();
  endtask

  initial begin
    int c0;
    logic [31:0] base;
    bit wr, rd;

    // Reset with a load request present: everything quiet.
    reset = 1'b1;
    idle_inputs();
    mem_read_in = 1'b1; mem_addr_in = 32'h1000_0000;
    for (int i = 0; i < 256; i++) begin
      case (i / 64)
        0:       base = 32'h1000_0000;
        1:       base = 32'h7fff_f000;
        2:       base = 32'hffff_0000;
        default: base = 32'h0000_0000;
      endcase
      set_word(base + 32'(4 * (i % 64)), $urandom);
    end
    @(negedge clock); #1;
    check("rst_rdata", mem_rdata_out, 32'h0);
    check("rst_re", {31'h0, dm_re_out}, 32'h0);
    check("rst_addr", dm_addr_out, 32'h0);
    check("rst_size", {30'h0, dm_size_out}, 32'h3);
    mem_read_in = 1'b0; mem_write_in = 1'b1; mem_size_in = 2'b00; #1;
    check("rst_we", {31'h0, dm_we_out}, 32'h0);
    check("rst_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle_inputs();

    // Signed byte loads in a big-endian word.
    set_word(32'h1000_0004, 32'h1122_3344);
    op(1'b0, 1'b1, 2'b00, 1'b1, 32'h1000_0006, 32'h0);
    check("t1_byte", last_rdata, 32'h0000_0033);
    set_word(32'h1000_0004, 32'h1122_8044);
    op(1'b0, 1'b1, 2'b00, 1'b1, 32'h1000_0006, 32'h0);
    check("t1_sbyte", last_rdata, 32'hffff_ff80);

    // Halfword RMW, then a load sees the merged word.
    set_word(32'h1000_0008, 32'haabb_ccdd);
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h1000_000a, 32'h0000_1234);
    check("t2_wdata", last_wdata, 32'haabb_1234);
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h1000_0008, 32'h0);
    check("t2_load", last_rdata, 32'haabb_1234);

    // MMIO byte store: single write, zero-extended low byte.
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'hffff_0000, 32'hdead_be41);
    check("t3_wdata", last_wdata, 32'h0000_0041);

    // Misaligned word load.
    set_word(32'h1000_0000, 32'hcafe_f00d);
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h1000_0002, 32'h0);
    if (TRAP) check("t4_rdata", last_rdata, 32'h0);
    else      check("t4_addr", last_addr, 32'h1000_0000);

    // Reset during RMW_WRITE drops the write.
    set_word(32'h7fff_f000, 32'h0102_0304);
    @(negedge clock);
    mem_write_in = 1'b1; mem_size_in = 2'b00; mem_addr_in = 32'h7fff_f000; mem_wdata_in = 32'h0000_00ee;
    #1 check("t5_stall", {31'h0, stall_out}, 32'h1);
    @(posedge clock); #1;
    reset = 1'b1; #1;
    check("t5_we", {31'h0, dm_we_out}, 32'h0);
    check("t5_wdata", dm_wdata_out, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle_inputs();
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h7fff_f000, 32'h0);
    check("t5_mem", last_rdata, 32'h0102_0304);

    // Back-to-back byte RMWs into one word: four cycles.
    c0 = cyc;
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000_0010, 32'h0000_00a5);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000_0013, 32'h0000_005a);
    check("t6_cycles", 32'(cyc - c0), 32'd4);
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h1000_0010, 32'h0);
    check("t6_byte0", {24'h0, last_rdata[31:24]}, 32'h0000_00a5);
    check("t6_byte3", {24'h0, last_rdata[7:0]}, 32'h0000_005a);

    // Randomized mix of loads and stores.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0:       base = 32'h1000_0000;
        1:       base = 32'h7fff_f000;
        default: base = 32'hffff_0000;
      endcase
      wr = ($urandom_range(0, 1) == 1);
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      op(wr, rd, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
         base + 32'($urandom_range(0, 255)), $urandom);
    end

    // Whole-memory sweep against the byte model.
    for (int i = 0; i < 192; i++) begin
      case (i / 64)
        0:       base = 32'h1000_0000;
        1:       base = 32'h7fff_f000;
        default: base = 32'hffff_0000;
      endcase
      base = base + 32'(4 * (i % 64));
      check("mem_sweep", dmem[widx(base)], ref_word(base));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
